// File: rtl/neuron_pkg.sv
// neuron_pkg: shared FSM type, width and saturation helpers for the neuron.
// Saturation runs on a wide signed carrier so one helper serves any width.
package neuron_pkg;

    typedef enum logic [1:0] {IDLE, ACC, FIN, OUT} state_t;

    localparam int SW = 128;
    typedef logic signed [SW-1:0] wide_t;

    function automatic int acc_width(input int width, input int n);
        return 2 * width + $clog2(n) + 1;
    endfunction

    function automatic wide_t sat_to(input wide_t v, input int width);
        wide_t hi;
        wide_t lo;
        wide_t r;
        hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        r = v;
        if (v > hi) r = hi;
        if (v < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/neuron_proj_sat.sv
// neuron_proj_sat: rescale, saturate, bias-add and optional ReLU of the
// accumulated dot product. Purely combinational.
module neuron_proj_sat
    import neuron_pkg::*;
#(
    parameter int IW = 35,
    parameter int OW = 16,
    parameter int FRAC = 0,
    parameter logic signed [OW-1:0] BIAS = '0,
    parameter bit RELU = 1'b0
) (
    input  logic signed [IW-1:0] acc,
    output logic signed [OW-1:0] res
);

    localparam wide_t BX = {{(SW-OW){BIAS[OW-1]}}, BIAS};

    wide_t ext;
    wide_t s;
    wide_t p;
    wide_t b;

    always_comb begin
        ext = {{(SW-IW){acc[IW-1]}}, acc};
        s = ext >>> FRAC;
        p = sat_to(s, OW);
        // Bias add in the wide carrier, then clamp: never wraps.
        b = sat_to(p + BX, OW);
        if (RELU && b < 0) b = '0;
        res = b[OW-1:0];
    end

endmodule

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: handshaked constant-weight neuron, dot product
// time-multiplexed over LANES multipliers, then rescale/saturate/bias/ReLU.
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N = 4,
    parameter int LANES = 1,
    parameter int FRAC = 0,
    parameter logic [N*WIDTH-1:0] WEIGHTS_FLAT = '0,
    parameter logic signed [WIDTH-1:0] BIAS = '0,
    parameter bit RELU = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N*WIDTH-1:0]      in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int ACC_W = acc_width(WIDTH, N);
    localparam int IDX_W = $clog2(N + LANES + 1);

    state_t state;
    state_t state_nx;

    logic [N*WIDTH-1:0]      vec;
    logic signed [ACC_W-1:0] acc;
    logic [IDX_W-1:0]        idx;

    logic signed [ACC_W-1:0]   step_sum;
    logic signed [WIDTH-1:0]   w;
    logic signed [WIDTH-1:0]   x;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0]   post;
    int                        elem;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (in_valid) state_nx = ACC;
            ACC:  if (int'(idx) + LANES >= N) state_nx = FIN;
            FIN:  state_nx = OUT;
            OUT:  if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == OUT);
    end

    // Lanes past the last element contribute nothing.
    always_comb begin
        step_sum = '0;
        elem = 0;
        w = '0;
        x = '0;
        prod = '0;
        for (int l = 0; l < LANES; l++) begin
            elem = int'(idx) + l;
            w = '0;
            x = '0;
            if (elem < N) begin
                w = WEIGHTS_FLAT[(N-elem)*WIDTH-1 -: WIDTH];
                x = vec[(N-elem)*WIDTH-1 -: WIDTH];
            end
            prod = w * x;
            step_sum = step_sum + ACC_W'(prod);
        end
    end

    neuron_proj_sat #(
        .IW(ACC_W),
        .OW(WIDTH),
        .FRAC(FRAC),
        .BIAS(BIAS),
        .RELU(RELU)
    ) u_proj (
        .acc(acc),
        .res(post)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vec      <= '0;
            acc      <= '0;
            idx      <= '0;
            out_data <= '0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    vec <= in_data;
                    acc <= '0;
                    idx <= '0;
                end
                ACC: begin
                    acc <= acc + step_sum;
                    idx <= idx + IDX_W'(LANES);
                end
                FIN: out_data <= post;
                default: ;
            endcase
        end
    end

endmodule
